// File: rtl/banco_pkg.sv
// Shared defaults and types for the
// parameterised register file.
package banco_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int NREGS_DEF = 32;

  typedef logic [XLEN_DEF-1:0] word_t;

endpackage

// File: rtl/banco_registros_param_marcador_regs.sv
// Busy-bit scoreboard: one reservation bit
// per register plus a running pending count.
module marcador_regs
  import banco_pkg::*;
#(
  parameter int NREGS = NREGS_DEF,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          set_en,
  input  logic [AW-1:0] set_idx,
  input  logic          clr_en,
  input  logic [AW-1:0] clr_idx,
  output logic [(1<<AW)-1:0] busy,
  output logic [AW:0]   pend_count
);

  localparam int DEPTH = 1 << AW;
  localparam logic [AW:0] ONE = 1;

  logic [DEPTH-1:0] busy_nxt;
  logic             inc;
  logic             dec;
  logic             same;

  // Next busy vector: a set beats a clear on the same index.
  always_comb begin
    busy_nxt = busy;
    same     = set_en && clr_en && (set_idx == clr_idx);
    inc      = set_en && !busy[set_idx];
    dec      = clr_en && busy[clr_idx] && !same;
    if (clr_en) busy_nxt[clr_idx] = 1'b0;
    if (set_en) busy_nxt[set_idx] = 1'b1;
  end

  // Busy bits latch their next value each edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy <= '0;
    else        busy <= busy_nxt;
  end

  // Pending count tracks each 0->1 and 1->0 bit transition.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_count <= '0;
    end else begin
      unique case ({inc, dec})
        2'b10:   pend_count <= pend_count + ONE;
        2'b01:   pend_count <= pend_count - ONE;
        default: pend_count <= pend_count;
      endcase
    end
  end

endmodule

// File: rtl/banco_registros_param.sv
// Register file with same-cycle forwarding
// and a busy scoreboard for in-flight writers.
module banco_registros_param
  import banco_pkg::*;
#(
  parameter int XLEN   = XLEN_DEF,
  parameter int NREGS  = NREGS_DEF,
  parameter bit BYPASS = 1'b1,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic            CLK,
  input  logic            RESET_N,
  input  logic [AW-1:0]   readReg1,
  input  logic [AW-1:0]   readReg2,
  output logic [XLEN-1:0] readData1,
  output logic [XLEN-1:0] readData2,
  input  logic            RegWrite,
  input  logic [AW-1:0]   writeReg,
  input  logic [XLEN-1:0] writeData,
  input  logic            Issue,
  input  logic [AW-1:0]   issueReg,
  output logic            busy1,
  output logic            busy2,
  output logic            stall,
  output logic [AW:0]     pendCount
);

  localparam logic [AW:0] NLIM = NREGS[AW:0];

  logic [XLEN-1:0]    regs [NREGS];
  logic [(1<<AW)-1:0] busy;
  logic               wr_ok;
  logic               iss_ok;
  logic               fwd1;
  logic               fwd2;

  function automatic logic idx_ok(
    input logic [AW-1:0] idx
  );
    return (idx != '0) && ({1'b0, idx} < NLIM);
  endfunction

  // Qualify write and issue against x0 and out-of-range indices.
  always_comb begin
    wr_ok  = RegWrite && idx_ok(writeReg);
    iss_ok = Issue && idx_ok(issueReg);
  end

  // Data array; x0 is never written so it stays zero.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (wr_ok) begin
      regs[writeReg] <= writeData;
    end
  end

  // Read muxes with optional forwarding, suppressed during reset.
  always_comb begin
    fwd1 = BYPASS && RESET_N && wr_ok &&
           (writeReg == readReg1);
    fwd2 = BYPASS && RESET_N && wr_ok &&
           (writeReg == readReg2);
    if (!idx_ok(readReg1)) readData1 = '0;
    else if (fwd1)         readData1 = writeData;
    else                   readData1 = regs[readReg1];
    if (!idx_ok(readReg2)) readData2 = '0;
    else if (fwd2)         readData2 = writeData;
    else                   readData2 = regs[readReg2];
  end

  // Busy flags: a forwarded result clears the hazard this cycle.
  always_comb begin
    busy1 = busy[readReg1] && !fwd1;
    busy2 = busy[readReg2] && !fwd2;
    stall = busy1 || busy2;
  end

  marcador_regs #(
    .NREGS (NREGS),
    .AW    (AW)
  ) u_marcador (
    .clk        (CLK),
    .rst_n      (RESET_N),
    .set_en     (iss_ok),
    .set_idx    (issueReg),
    .clr_en     (wr_ok),
    .clr_idx    (writeReg),
    .busy       (busy),
    .pend_count (pendCount)
  );

endmodule

// File: tb/tb_banco_registros_param.sv
// Scenario bench: bypass, no-bypass and a
// non-power-of-two instance share one stimulus.
module tb_banco_registros_param;

  logic        CLK;
  logic        RESET_N;
  logic [4:0]  rr1, rr2, wr, ir;
  logic        rw, iss;
  logic [31:0] wd;

  logic [31:0] rd1_a, rd2_a, rd1_b, rd2_b;
  logic [31:0] rd1_c, rd2_c;
  logic        b1_a, b2_a, st_a;
  logic        b1_b, b2_b, st_b;
  logic        b1_c, b2_c, st_c;
  logic [5:0]  pc_a, pc_b, pc_c;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] exp_q[$];
  logic [4:0]  idx_q[$];
  logic [31:0] exp;

  banco_registros_param #(
    .XLEN(32), .NREGS(32), .BYPASS(1'b1)
  ) dut_a (
    .CLK(CLK), .RESET_N(RESET_N),
    .readReg1(rr1), .readReg2(rr2),
    .readData1(rd1_a), .readData2(rd2_a),
    .RegWrite(rw), .writeReg(wr),
    .writeData(wd), .Issue(iss),
    .issueReg(ir), .busy1(b1_a),
    .busy2(b2_a), .stall(st_a),
    .pendCount(pc_a)
  );

  banco_registros_param #(
    .XLEN(32), .NREGS(32), .BYPASS(1'b0)
  ) dut_b (
    .CLK(CLK), .RESET_N(RESET_N),
    .readReg1(rr1), .readReg2(rr2),
    .readData1(rd1_b), .readData2(rd2_b),
    .RegWrite(rw), .writeReg(wr),
    .writeData(wd), .Issue(iss),
    .issueReg(ir), .busy1(b1_b),
    .busy2(b2_b), .stall(st_b),
    .pendCount(pc_b)
  );

  banco_registros_param #(
    .XLEN(32), .NREGS(20), .BYPASS(1'b1)
  ) dut_c (
    .CLK(CLK), .RESET_N(RESET_N),
    .readReg1(rr1), .readReg2(rr2),
    .readData1(rd1_c), .readData2(rd2_c),
    .RegWrite(rw), .writeReg(wr),
    .writeData(wd), .Issue(iss),
    .issueReg(ir), .busy1(b1_c),
    .busy2(b2_c), .stall(st_c),
    .pendCount(pc_c)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    rw  = 1'b0;
    iss = 1'b0;
  endtask

  task automatic test_reset();
    RESET_N = 1'b0;
    rr1 = '0; rr2 = '0; wr = '0; ir = '0;
    rw = 1'b0; iss = 1'b0; wd = '0;
    #12;
    RESET_N = 1'b1;
    step();
    for (int i = 0; i < 32; i++) begin
      rr1 = 5'(i);
      rr2 = 5'(31 - i);
      exp_q.push_back(32'h0);
      exp_q.push_back(32'h0);
      #1;
      exp = exp_q.pop_front();
      n_tests++;
      if (rd1_a !== exp) begin
        n_fail++;
        $display("FAIL reset_rd1 x%0d got %h want %h",
                 i, rd1_a, exp);
      end
      exp = exp_q.pop_front();
      n_tests++;
      if (rd2_b !== exp) begin
        n_fail++;
        $display("FAIL reset_rd2 x%0d got %h want %h",
                 31 - i, rd2_b, exp);
      end
    end
    n_tests++;
    if (pc_a !== 6'd0 || st_a !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_pc got %0d/%b want 0/0",
               pc_a, st_a);
    end
  endtask

  task automatic test_bypass();
    step();
    rw = 1'b1; wr = 5'd5;
    wd = 32'hDEADBEEF; rr1 = 5'd5;
    exp_q.push_back(32'hDEADBEEF);
    exp_q.push_back(32'h0);
    #1;
    exp = exp_q.pop_front();
    n_tests++;
    if (rd1_a !== exp) begin
      n_fail++;
      $display("FAIL bypass_same got %h want %h",
               rd1_a, exp);
    end
    exp = exp_q.pop_front();
    n_tests++;
    if (rd1_b !== exp) begin
      n_fail++;
      $display("FAIL nobypass_old got %h want %h",
               rd1_b, exp);
    end
    step();
    idle();
    exp_q.push_back(32'hDEADBEEF);
    #1;
    exp = exp_q.pop_front();
    n_tests++;
    if (rd1_b !== exp) begin
      n_fail++;
      $display("FAIL nobypass_next got %h want %h",
               rd1_b, exp);
    end
  endtask

  task automatic test_x0();
    rw = 1'b1; wr = 5'd0;
    wd = 32'h1234; rr1 = 5'd0;
    #1;
    n_tests++;
    if (rd1_a !== 32'h0) begin
      n_fail++;
      $display("FAIL x0_fwd got %h want 0", rd1_a);
    end
    step();
    idle();
    #1;
    n_tests++;
    if (rd1_a !== 32'h0 || rd1_b !== 32'h0) begin
      n_fail++;
      $display("FAIL x0_read got %h/%h want 0",
               rd1_a, rd1_b);
    end
    iss = 1'b1; ir = 5'd0; rr2 = 5'd0;
    step();
    idle();
    #1;
    n_tests++;
    if (b2_a !== 1'b0 || pc_a !== 6'd0) begin
      n_fail++;
      $display("FAIL x0_issue got %b/%0d want 0/0",
               b2_a, pc_a);
    end
  endtask

  task automatic test_scoreboard();
    logic [5:0] want [3];
    want[0] = 6'd1; want[1] = 6'd2; want[2] = 6'd2;
    for (int k = 0; k < 3; k++) begin
      iss = 1'b1;
      ir  = (k == 1) ? 5'd7 : 5'd3;
      step();
      idle();
      n_tests++;
      if (pc_a !== want[k]) begin
        n_fail++;
        $display("FAIL issue_pc%0d got %0d want %0d",
                 k, pc_a, want[k]);
      end
    end
    rr2 = 5'd7;
    #1;
    n_tests++;
    if (b2_a !== 1'b1 || st_a !== 1'b1) begin
      n_fail++;
      $display("FAIL busy7 got %b/%b want 1/1",
               b2_a, st_a);
    end
    rw = 1'b1; wr = 5'd7; wd = 32'h77;
    #1;
    n_tests++;
    if (b2_a !== 1'b0 || b2_b !== 1'b1) begin
      n_fail++;
      $display("FAIL busy7_wb got %b/%b want 0/1",
               b2_a, b2_b);
    end
    step();
    idle();
    #1;
    n_tests++;
    if (pc_a !== 6'd1 || b2_b !== 1'b0) begin
      n_fail++;
      $display("FAIL wb_pc got %0d/%b want 1/0",
               pc_a, b2_b);
    end
  endtask

  task automatic test_issue_write();
    logic [31:0] val  [2];
    logic [5:0]  wpc  [2];
    val[0] = 32'hA5; val[1] = 32'h5A;
    wpc[0] = 6'd2;   wpc[1] = 6'd2;
    for (int k = 0; k < 2; k++) begin
      iss = 1'b1; ir = 5'd9;
      rw = 1'b1; wr = 5'd9; wd = val[k];
      exp_q.push_back(val[k]);
      step();
      idle();
      rr1 = 5'd9;
      #1;
      exp = exp_q.pop_front();
      n_tests++;
      if (rd1_a !== exp || b1_a !== 1'b1 ||
          pc_a !== wpc[k]) begin
        n_fail++;
        $display("FAIL iw%0d got %h/%b/%0d want %h/1/%0d",
                 k, rd1_a, b1_a, pc_a, exp, wpc[k]);
      end
    end
  endtask

  task automatic test_out_of_range();
    rw = 1'b1; wr = 5'd25; wd = 32'hFFFF;
    iss = 1'b1; ir = 5'd25; rr1 = 5'd25;
    #1;
    n_tests++;
    if (rd1_c !== 32'h0) begin
      n_fail++;
      $display("FAIL oor_fwd got %h want 0", rd1_c);
    end
    step();
    idle();
    #1;
    n_tests++;
    if (rd1_c !== 32'h0 || b1_c !== 1'b0 ||
        pc_c !== 6'd2) begin
      n_fail++;
      $display("FAIL oor got %h/%b/%0d want 0/0/2",
               rd1_c, b1_c, pc_c);
    end
    n_tests++;
    if (rd1_a !== 32'hFFFF || pc_a !== 6'd3) begin
      n_fail++;
      $display("FAIL in_range got %h/%0d want ffff/3",
               rd1_a, pc_a);
    end
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 4; k++) begin
      rw = 1'b1;
      wr = 5'(10 + k);
      wd = 32'h1000 + 32'(k * 3);
      idx_q.push_back(wr);
      exp_q.push_back(wd);
      step();
    end
    idle();
    while (idx_q.size() > 0) begin
      rr2 = idx_q.pop_front();
      exp = exp_q.pop_front();
      #1;
      n_tests++;
      if (rd2_a !== exp || rd2_b !== exp) begin
        n_fail++;
        $display("FAIL b2b x%0d got %h/%h want %h",
                 rr2, rd2_a, rd2_b, exp);
      end
    end
  endtask

  task automatic test_reset_mid();
    for (int k = 1; k <= 4; k++) begin
      iss = 1'b1; ir = 5'(k);
      step();
    end
    idle();
    rw = 1'b1; wr = 5'd5; wd = 32'h123;
    rr1 = 5'd5; rr2 = 5'd1;
    #2;
    RESET_N = 1'b0;
    #1;
    n_tests++;
    if (pc_a !== 6'd0 || b2_a !== 1'b0 ||
        st_a !== 1'b0) begin
      n_fail++;
      $display("FAIL rmid_sb got %0d/%b/%b want 0/0/0",
               pc_a, b2_a, st_a);
    end
    n_tests++;
    if (rd1_a !== 32'h0 || rd1_b !== 32'h0) begin
      n_fail++;
      $display("FAIL rmid_data got %h/%h want 0",
               rd1_a, rd1_b);
    end
    rw = 1'b0;
    #1;
    RESET_N = 1'b1;
    iss = 1'b1; ir = 5'd2;
    step();
    idle();
    rr1 = 5'd2; rr2 = 5'd10;
    #1;
    n_tests++;
    if (pc_a !== 6'd1 || b1_a !== 1'b1) begin
      n_fail++;
      $display("FAIL rmid_after got %0d/%b want 1/1",
               pc_a, b1_a);
    end
    n_tests++;
    if (rd2_a !== 32'h0) begin
      n_fail++;
      $display("FAIL rmid_lost got %h want 0", rd2_a);
    end
  endtask

  initial begin
    test_reset();
    test_bypass();
    test_x0();
    test_scoreboard();
    test_issue_write();
    test_out_of_range();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
